// File: rtl/bcd_time_decoder.sv
// Keypad digit entry buffer (MM:SS, BCD) with a time-multiplexed
// four-digit seven-segment display driver.
module bcd_time_decoder #(
   parameter int SCAN_DIV = 100,
   parameter int CNT_W    = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  bcd_in,
   input  logic        bcd_valid,
   input  logic        load_en,
   input  logic        clear,
   output logic [15:0] time_out,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        entry_err
);

   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

   logic [15:0]      buffer;
   logic [CNT_W-1:0] scan_cnt;
   logic [1:0]       idx;
   logic [3:0]       cur_digit;
   logic             digit_ok;

   function automatic logic [6:0] decode_seg(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h7E;
         4'd1:    return 7'h30;
         4'd2:    return 7'h6D;
         4'd3:    return 7'h79;
         4'd4:    return 7'h33;
         4'd5:    return 7'h5B;
         4'd6:    return 7'h5F;
         4'd7:    return 7'h70;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h7B;
         default: return 7'h00;
      endcase
   endfunction

   assign digit_ok = (bcd_in <= 4'd9);

   // clear outranks a same-cycle strobe; bad codes leave the buffer intact
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buffer    <= 16'h0000;
         entry_err <= 1'b0;
      end else begin
         entry_err <= 1'b0;
         if (clear) begin
            buffer <= 16'h0000;
         end else if (bcd_valid && load_en) begin
            if (digit_ok) begin
               buffer <= {buffer[11:0], bcd_in};
            end else begin
               entry_err <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         idx      <= 2'd0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         idx      <= idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   always_comb begin
      cur_digit = buffer[3:0];
      case (idx)
         2'd0: cur_digit = buffer[3:0];
         2'd1: cur_digit = buffer[7:4];
         2'd2: cur_digit = buffer[11:8];
         2'd3: cur_digit = buffer[15:12];
         default: cur_digit = buffer[3:0];
      endcase
   end

   assign time_out = buffer;
   assign an       = 4'b0001 << idx;
   assign seg      = decode_seg(cur_digit);

endmodule

// File: tb/tb_bcd_time_decoder.sv
// Self-checking bench for bcd_time_decoder: directed scenarios plus
// randomized entry traffic against a decimal-number reference model.
module tb_bcd_time_decoder;

   localparam int SCAN_DIV = 100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  bcd_in;
   logic        bcd_valid;
   logic        load_en;
   logic        clear;
   logic [15:0] time_out;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        entry_err;

   int n_checks = 0;
   int n_err    = 0;

   bcd_time_decoder #(.SCAN_DIV(SCAN_DIV), .CNT_W(7)) dut (
      .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
      .load_en(load_en), .clear(clear), .time_out(time_out), .seg(seg),
      .an(an), .entry_err(entry_err)
   );

   always #5 clk = ~clk;

   // Reference model: the entry is a plain decimal number 0..9999,
   // the scan position is clocks since reset modulo four digit slots.
   int m_val;
   int m_cyc;
   bit m_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_val <= 0;
         m_cyc <= 0;
         m_err <= 1'b0;
      end else begin
         m_cyc <= (m_cyc + 1) % (4 * SCAN_DIV);
         m_err <= 1'b0;
         if (clear) m_val <= 0;
         else if (bcd_valid && load_en) begin
            if (int'(bcd_in) <= 9) m_val <= (m_val * 10 + int'(bcd_in)) % 10000;
            else m_err <= 1'b1;
         end
      end
   end

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic logic [6:0] seg_of(input int d);
      logic [6:0] tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
      return tab[d];
   endfunction

   function automatic logic [27:0] exp_vec();
      int p10 [4] = '{1, 10, 100, 1000};
      int slot = m_cyc / SCAN_DIV;
      int dig  = (m_val / p10[slot]) % 10;
      return {to_bcd(m_val), 4'(1 << slot), seg_of(dig), m_err};
   endfunction

   task automatic idle_inputs();
      bcd_valid = 1'b0;
      bcd_in    = 4'd0;
      load_en   = 1'b1;
      clear     = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_checks++;
      if ({time_out, an, seg, entry_err} !== {16'h0000, 4'b0001, 7'h7E, 1'b0}) begin
         n_err++;
         $display("FAIL reset_values got=%h required=%h", {time_out, an, seg, entry_err},
                  {16'h0000, 4'b0001, 7'h7E, 1'b0});
      end
      for (int k = 1; k <= 4 * SCAN_DIV; k++) begin
         @(negedge clk);
         n_checks++;
         if ({time_out, an, seg, entry_err} !== exp_vec()) begin
            n_err++;
            $display("FAIL scan_model clk=%0d got=%h required=%h", k,
                     {time_out, an, seg, entry_err}, exp_vec());
         end
         if (k == SCAN_DIV - 1 || k == SCAN_DIV || k == 4 * SCAN_DIV) begin
            n_checks++;
            if (an !== ((k == SCAN_DIV) ? 4'b0010 : 4'b0001)) begin
               n_err++;
               $display("FAIL scan_an clk=%0d got=%b required=%b", k, an,
                        (k == SCAN_DIV) ? 4'b0010 : 4'b0001);
            end
         end
      end
   endtask

   task automatic test_entry();
      int digs [4] = '{1, 2, 3, 0};
      bit found = 1'b0;
      load_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bcd_valid = 1'b1;
         bcd_in    = 4'(digs[i]);
         @(negedge clk);
         bcd_valid = 1'b0;
         n_checks++;
         if ({time_out, an, seg, entry_err} !== exp_vec()) begin
            n_err++;
            $display("FAIL entry_model step=%0d got=%h required=%h", i,
                     {time_out, an, seg, entry_err}, exp_vec());
         end
      end
      n_checks++;
      if (time_out !== 16'h1230) begin
         n_err++;
         $display("FAIL entry_1230 got=%h required=%h", time_out, 16'h1230);
      end
      for (int k = 0; k < 5 * SCAN_DIV && !found; k++) begin
         @(negedge clk);
         if (an === 4'b1000) found = 1'b1;
      end
      n_checks++;
      if (!found || seg !== 7'h30) begin
         n_err++;
         $display("FAIL m1_slot found=%0d an=%b seg=%h required an=1000 seg=30", found, an, seg);
      end
   endtask

   task automatic test_overflow();
      bcd_valid = 1'b1;
      bcd_in    = 4'd5;
      @(negedge clk);
      bcd_valid = 1'b0;
      n_checks++;
      if (time_out !== 16'h2305) begin
         n_err++;
         $display("FAIL overflow got=%h required=%h", time_out, 16'h2305);
      end
   endtask

   task automatic test_bad_code();
      bcd_valid = 1'b1;
      bcd_in    = 4'hC;
      @(negedge clk);
      bcd_valid = 1'b0;
      n_checks++;
      if ({entry_err, time_out} !== {1'b1, 16'h2305}) begin
         n_err++;
         $display("FAIL bad_code_err got=%h required=%h", {entry_err, time_out}, {1'b1, 16'h2305});
      end
      @(negedge clk);
      n_checks++;
      if (entry_err !== 1'b0) begin
         n_err++;
         $display("FAIL bad_code_pulse got=%b required=0", entry_err);
      end
      load_en   = 1'b0;
      bcd_valid = 1'b1;
      @(negedge clk);
      bcd_valid = 1'b0;
      n_checks++;
      if ({entry_err, time_out} !== {1'b0, 16'h2305}) begin
         n_err++;
         $display("FAIL bad_code_locked got=%h required=%h", {entry_err, time_out}, {1'b0, 16'h2305});
      end
      bcd_in    = 4'd8;
      bcd_valid = 1'b1;
      @(negedge clk);
      bcd_valid = 1'b0;
      load_en   = 1'b1;
      n_checks++;
      if ({entry_err, time_out} !== {1'b0, 16'h2305}) begin
         n_err++;
         $display("FAIL good_code_locked got=%h required=%h", {entry_err, time_out}, {1'b0, 16'h2305});
      end
   endtask

   task automatic test_clear();
      clear     = 1'b1;
      bcd_valid = 1'b1;
      bcd_in    = 4'd7;
      @(negedge clk);
      clear     = 1'b0;
      bcd_valid = 1'b0;
      n_checks++;
      if ({time_out, entry_err} !== {16'h0000, 1'b0}) begin
         n_err++;
         $display("FAIL clear got=%h required=%h", {time_out, entry_err}, {16'h0000, 1'b0});
      end
      for (int k = 0; k < 2 * SCAN_DIV; k++) begin
         @(negedge clk);
         n_checks++;
         if ({time_out, an, seg, entry_err} !== exp_vec()) begin
            n_err++;
            $display("FAIL clear_scan clk=%0d got=%h required=%h", k,
                     {time_out, an, seg, entry_err}, exp_vec());
         end
      end
   endtask

   task automatic test_random(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         bcd_valid = ($urandom % 3) == 0;
         bcd_in    = 4'($urandom % 16);
         load_en   = ($urandom % 5) != 0;
         clear     = ($urandom % 40) == 0;
         @(negedge clk);
         n_checks++;
         if ({time_out, an, seg, entry_err} !== exp_vec()) begin
            n_err++;
            $display("FAIL random clk=%0d got=%h required=%h", k,
                     {time_out, an, seg, entry_err}, exp_vec());
         end
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         bcd_valid = 1'b1;
         bcd_in    = 4'(i + 4);
         @(negedge clk);
      end
      bcd_valid = 1'b0;
      repeat ($urandom_range(5, 60)) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({time_out, an, seg, entry_err} !== {16'h0000, 4'b0001, 7'h7E, 1'b0}) begin
         n_err++;
         $display("FAIL async_reset got=%h required=%h", {time_out, an, seg, entry_err},
                  {16'h0000, 4'b0001, 7'h7E, 1'b0});
      end
      @(negedge clk);
      #3 rst_n = 1'b1;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         n_checks++;
         if ({time_out, an, seg, entry_err} !== exp_vec()) begin
            n_err++;
            $display("FAIL after_reset clk=%0d got=%h required=%h", k,
                     {time_out, an, seg, entry_err}, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_entry();
      test_overflow();
      test_bad_code();
      test_clear();
      test_random(3000);
      test_async_reset();
      test_random(1500);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
